// File: rtl/rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_read_sequencer
// Description : Walks a parameterised list of RTC register addresses over a
//               multiplexed address/data bus. Each register is read as an
//               ADDR phase, a CMD phase and a DATA phase. The returned byte is
//               captured and tagged with its list index. Supports a
//               start/busy/done handshake, a hold freeze and a continuous
//               loop mode.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_read_sequencer #(
    parameter int                         DATA_W    = 8,
    parameter int                         NUM_REGS  = 9,
    parameter logic [NUM_REGS*DATA_W-1:0] ADDR_LIST = 72'h42_41_26_25_24_23_22_21_43,
    parameter logic [DATA_W-1:0]          CMD_BYTE  = 8'hF0,
    parameter logic [DATA_W-1:0]          IDLE_VAL  = 8'hFF,
    parameter int                         PHASE_CYC = 2,
    parameter int                         IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    input  logic              loop,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              a_d,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    output logic [IDX_W-1:0]  rd_index,
    output logic [DATA_W-1:0] rd_data
);

    localparam int               PH_W     = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(PHASE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_CMD  = 2'd2,
        S_DATA = 2'd3
    } state_t;

    state_t             r_state;
    logic [PH_W-1:0]    r_phase;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [DATA_W-1:0]  w_addr_tab [NUM_REGS];
    logic               w_phase_last;

    // Unpack the flat address list into an indexable table
    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_addr_tab
            assign w_addr_tab[g] = ADDR_LIST[g*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_idx_inc    = r_idx + IDX_W'(1);
    assign w_phase_last = (r_phase == LAST_PH);

    // Sequencer FSM; bus outputs are registered from the next-state decision
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_idx    <= '0;
            bus_out  <= IDLE_VAL;
            a_d      <= 1'b1;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_index <= '0;
            rd_data  <= '0;
        end else if (hold) begin
            // Freeze everything; pulses stay low so a pending capture is
            // simply taken on the first non-held last-DATA edge.
            done     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ADDR;
                        r_phase <= '0;
                        r_idx   <= '0;
                        bus_out <= w_addr_tab[0];
                        a_d     <= 1'b0;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (w_phase_last) begin
                        r_phase <= '0;
                        r_state <= S_CMD;
                        bus_out <= CMD_BYTE;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                S_CMD: begin
                    if (w_phase_last) begin
                        r_phase <= '0;
                        r_state <= S_DATA;
                        bus_out <= IDLE_VAL;
                        a_d     <= 1'b1;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_phase_last) begin
                        r_phase  <= '0;
                        rd_data  <= bus_in;
                        rd_index <= r_idx;
                        rd_valid <= 1'b1;
                        if (r_idx != LAST_IDX) begin
                            r_idx   <= w_idx_inc;
                            r_state <= S_ADDR;
                            bus_out <= w_addr_tab[w_idx_inc];
                            a_d     <= 1'b0;
                        end else begin
                            done  <= 1'b1;
                            r_idx <= '0;
                            if (loop) begin
                                r_state <= S_ADDR;
                                bus_out <= w_addr_tab[0];
                                a_d     <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                bus_out <= IDLE_VAL;
                                a_d     <= 1'b1;
                                cs_n    <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_read_sequencer
// Description : Scoreboard bench for rtc_read_sequencer. Expected bus bytes
//               and captures are queued by the stimulus; monitors pop and
//               compare whenever the DUT drives the bus or pulses rd_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_read_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, hold, loop;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       a_d, cs_n, busy, done, rd_valid;
    logic [3:0] rd_index;
    logic [7:0] rd_data;

    logic       start_b, hold_b, loop_b;
    logic [7:0] bus_in_b;
    logic [7:0] bus_out_b;
    logic       a_d_b, cs_n_b, busy_b, done_b, rd_valid_b;
    logic [0:0] rd_index_b;
    logic [7:0] rd_data_b;

    int checks = 0;
    int errors = 0;

    logic [9:0]  qa_bus [$];
    logic [12:0] qa_rd  [$];
    logic [9:0]  qb_bus [$];
    logic [9:0]  qb_rd  [$];

    logic [7:0] addrs_a [9] = '{8'h43, 8'h21, 8'h22, 8'h23, 8'h24,
                                8'h25, 8'h26, 8'h41, 8'h42};

    always #5 clk = ~clk;

    rtc_read_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .loop(loop),
        .bus_in(bus_in), .bus_out(bus_out), .a_d(a_d), .cs_n(cs_n),
        .busy(busy), .done(done), .rd_valid(rd_valid),
        .rd_index(rd_index), .rd_data(rd_data)
    );

    rtc_read_sequencer #(
        .NUM_REGS(2), .ADDR_LIST(16'hAA55), .PHASE_CYC(1)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .hold(hold_b), .loop(loop_b),
        .bus_in(bus_in_b), .bus_out(bus_out_b), .a_d(a_d_b), .cs_n(cs_n_b),
        .busy(busy_b), .done(done_b), .rd_valid(rd_valid_b),
        .rd_index(rd_index_b), .rd_data(rd_data_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // RTC register contents returned for each address
    function automatic logic [7:0] rtc_mem(input logic [7:0] addr);
        case (addr)
            8'h43: rtc_mem = 8'h10;
            8'h21: rtc_mem = 8'h11;
            8'h22: rtc_mem = 8'h12;
            8'h23: rtc_mem = 8'h13;
            8'h24: rtc_mem = 8'h14;
            8'h25: rtc_mem = 8'h15;
            8'h26: rtc_mem = 8'h16;
            8'h41: rtc_mem = 8'h17;
            8'h42: rtc_mem = 8'h18;
            8'h55: rtc_mem = 8'h5A;
            8'hAA: rtc_mem = 8'hA5;
            default: rtc_mem = 8'h00;
        endcase
    endfunction

    // Queue one register read on instance A: ADDR x2, CMD x(2+extra),
    // DATA x data_n, plus its capture record when rd is set
    task automatic push_reg_a(input int i, input int extra, input int data_n,
                              input bit rd, input bit last);
        repeat (2) qa_bus.push_back({1'b1, 1'b0, addrs_a[i]});
        repeat (2 + extra) qa_bus.push_back({1'b1, 1'b0, 8'hF0});
        repeat (data_n) qa_bus.push_back({1'b1, 1'b1, 8'hFF});
        if (rd) qa_rd.push_back({last, 4'(i), 8'h10 + 8'(i)});
    endtask

    task automatic push_seq_a(input int hold_reg, input int hold_n);
        for (int i = 0; i < 9; i++)
            push_reg_a(i, (i == hold_reg) ? hold_n : 0, 2, 1'b1, i == 8);
    endtask

    // Count negedges until done rises; expect it at exp_n
    task automatic wait_done(input bit is_b, input int n0, input int exp_n, input string name);
        int  n    = n0;
        bit  seen = 1'b0;
        while (!seen && n < n0 + 200) begin
            tick(1);
            n++;
            seen = is_b ? done_b : done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: done never seen, waited %0d cycles expected cycle %0d", name, n, exp_n);
        end else begin
            check(name, n, exp_n);
        end
    endtask

    // RTC model for instance A: latch address, return its data in DATA phase
    initial begin : resp_a
        logic [7:0] addr = 8'h00;
        bus_in = 8'hEE;
        forever begin
            @(negedge clk);
            if (!cs_n && !a_d && bus_out != 8'hF0) addr = bus_out;
            bus_in = (!cs_n && a_d) ? rtc_mem(addr) : 8'hEE;
        end
    end

    initial begin : resp_b
        logic [7:0] addr = 8'h00;
        bus_in_b = 8'hEE;
        forever begin
            @(negedge clk);
            if (!cs_n_b && !a_d_b && bus_out_b != 8'hF0) addr = bus_out_b;
            bus_in_b = (!cs_n_b && a_d_b) ? rtc_mem(addr) : 8'hEE;
        end
    end

    // Monitor for instance A
    initial begin : mon_a
        forever begin
            @(negedge clk);
            if (cs_n === 1'b0) begin
                if (qa_bus.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_bus_extra: got bus %0h a_d %0b with nothing expected", bus_out, a_d);
                end else check("a_bus", {busy, a_d, bus_out}, qa_bus.pop_front());
            end
            if (rd_valid === 1'b1) begin
                if (qa_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_rd_extra: got idx %0d data %0h with nothing expected", rd_index, rd_data);
                end else check("a_rd", {done, rd_index, rd_data}, qa_rd.pop_front());
            end else if (done !== 1'b0) begin
                checks++; errors++;
                $display("FAIL a_stray_done: got done %b expected 0", done);
            end
        end
    end

    // Monitor for instance B
    initial begin : mon_b
        forever begin
            @(negedge clk);
            if (cs_n_b === 1'b0) begin
                if (qb_bus.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_bus_extra: got bus %0h a_d %0b with nothing expected", bus_out_b, a_d_b);
                end else check("b_bus", {busy_b, a_d_b, bus_out_b}, qb_bus.pop_front());
            end
            if (rd_valid_b === 1'b1) begin
                if (qb_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_rd_extra: got idx %0d data %0h with nothing expected", rd_index_b, rd_data_b);
                end else check("b_rd", {done_b, rd_index_b, rd_data_b}, qb_rd.pop_front());
            end else if (done_b !== 1'b0) begin
                checks++; errors++;
                $display("FAIL b_stray_done: got done %b expected 0", done_b);
            end
        end
    end

    initial begin : stim
        reset = 1'b1; start = 1'b0; hold = 1'b0; loop = 1'b0;
        start_b = 1'b0; hold_b = 1'b0; loop_b = 1'b0;
        tick(3);
        check("reset_a", {bus_out, a_d, cs_n, busy, done, rd_valid, rd_index, rd_data},
              {8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00});
        check("reset_b", {bus_out_b, a_d_b, cs_n_b, busy_b, done_b, rd_valid_b, rd_index_b, rd_data_b},
              {8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        reset = 1'b0;
        tick(2);

        // Full sequence with 5 hold cycles inside the CMD phase of idx 3
        push_seq_a(3, 5);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("first_addr", {busy, a_d, cs_n, bus_out}, {1'b1, 1'b0, 1'b0, 8'h43});
        tick(20);
        hold = 1'b1;
        tick(5);
        hold = 1'b0;
        wait_done(1'b0, 25, 59, "hold_seq_len");
        check("hold_seq_idle", {cs_n, busy, a_d, bus_out}, {1'b1, 1'b0, 1'b1, 8'hFF});
        tick(3);

        // Loop mode: two passes, loop dropped during the second
        push_seq_a(-1, 0);
        push_seq_a(-1, 0);
        loop  = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(54);
        check("loop_wrap", {done, busy, cs_n, a_d, bus_out}, {1'b1, 1'b1, 1'b0, 1'b0, 8'h43});
        tick(6);
        loop = 1'b0;
        wait_done(1'b0, 60, 108, "loop_seq_len");
        check("loop_end_idle", {cs_n, busy}, {1'b1, 1'b0});
        tick(3);

        // Reset during the first DATA cycle of idx 5
        for (int i = 0; i < 5; i++) push_reg_a(i, 0, 2, 1'b1, 1'b0);
        push_reg_a(5, 0, 1, 1'b0, 1'b0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(34);
        reset = 1'b1;
        tick(1);
        check("abort_reset", {bus_out, a_d, cs_n, busy, done, rd_valid, rd_index, rd_data},
              {8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00});
        reset = 1'b0;
        tick(3);
        push_seq_a(-1, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(1'b0, 0, 54, "clean_seq_len");
        tick(3);

        // Instance B: PHASE_CYC=1, two registers, start mid-sequence ignored
        qb_bus.push_back({1'b1, 1'b0, 8'h55});
        qb_bus.push_back({1'b1, 1'b0, 8'hF0});
        qb_bus.push_back({1'b1, 1'b1, 8'hFF});
        qb_bus.push_back({1'b1, 1'b0, 8'hAA});
        qb_bus.push_back({1'b1, 1'b0, 8'hF0});
        qb_bus.push_back({1'b1, 1'b1, 8'hFF});
        qb_rd.push_back({1'b0, 1'b0, 8'h5A});
        qb_rd.push_back({1'b1, 1'b1, 8'hA5});
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        tick(2);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        wait_done(1'b1, 3, 6, "b_seq_len");
        tick(1);
        check("b_stays_idle", {cs_n_b, busy_b}, {1'b1, 1'b0});
        tick(3);

        check("qa_bus_empty", qa_bus.size(), 0);
        check("qa_rd_empty",  qa_rd.size(),  0);
        check("qb_bus_empty", qb_bus.size(), 0);
        check("qb_rd_empty",  qb_rd.size(),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_read_sequencer.md
Name: rtc_read_sequencer

Overview:
- Parametrised successor to the fixed-table RTC read decoder: autonomously walks a configurable list of RTC register addresses over the multiplexed address/data bus.
- For each register it drives the address byte, then the command byte, then releases the bus and captures the returned data.
- Adds what the fixed decoder lacks: its own phase/index counters, start/busy/done handshake, data capture with index tagging, and an optional continuous-loop mode.
- Sits between the top-level control FSM and the RTC bus pad logic.

Parameters:
- DATA_W, 8, bus and data width.
- NUM_REGS, 9, number of registers read per sequence (≥1).
- ADDR_LIST, 72'h42_41_26_25_24_23_22_21_43, packed NUM_REGS*DATA_W address table; entry i = ADDR_LIST[i*DATA_W +: DATA_W].
- CMD_BYTE, 8'hF0, byte driven in the command phase.
- IDLE_VAL, 8'hFF, bus value when released (idle and data phase).
- PHASE_CYC, 2, clock cycles per phase (≥1).
- IDX_W, $clog2(NUM_REGS) (min 1), register index width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a sequence; sampled only in IDLE.
- hold  in  1  freeze: state, counters and bus outputs hold their values.
- loop  in  1  continuous mode; sampled at the end of the last register.
- bus_in  in  DATA_W  data returned by the RTC.
- bus_out  out  DATA_W  byte driven onto the bus.
- a_d  out  1  0 = address/command phase, 1 = data phase or idle.
- cs_n  out  1  RTC chip select, active low.
- busy  out  1  high from the first ADDR cycle until return to IDLE.
- done  out  1  one-cycle pulse at the end of a sequence (every pass in loop mode).
- rd_valid  out  1  one-cycle pulse: rd_data/rd_index updated.
- rd_index  out  IDX_W  index of the register in rd_data.
- rd_data  out  DATA_W  captured register value.

Behaviour:
- Reset values: bus_out=IDLE_VAL, a_d=1, cs_n=1, busy=0, done=0, rd_valid=0, rd_index=0, rd_data=0. State is IDLE; phase counter and index are 0.
- Reset has priority over hold and start. Reset mid-sequence aborts immediately: no done, no rd_valid.
- States and outputs:
  - IDLE: bus_out=IDLE_VAL, a_d=1, cs_n=1, busy=0.
  - ADDR: bus_out=ADDR_LIST[idx], a_d=0, cs_n=0.
  - CMD: bus_out=CMD_BYTE, a_d=0, cs_n=0.
  - DATA: bus_out=IDLE_VAL, a_d=1, cs_n=0.
- IDLE→ADDR: start=1 and hold=0 at an edge. idx=0, phase counter=0. The first ADDR cycle is the next cycle (1-cycle latency).
- Each of ADDR, CMD and DATA lasts exactly PHASE_CYC cycles. The phase counter counts 0..PHASE_CYC-1, then the FSM advances ADDR→CMD→DATA.
- Last DATA cycle edge:
  - rd_data←bus_in, rd_index←idx, rd_valid=1 for the next cycle.
  - If idx<NUM_REGS-1: idx+1, go to ADDR.
  - Else: done=1 for the next cycle; idx←0; go to ADDR if loop=1, otherwise IDLE (cs_n=1, busy=0 that cycle).
- One register takes 3*PHASE_CYC cycles; a full sequence takes NUM_REGS*3*PHASE_CYC cycles.
- bus_in is sampled only on the last DATA cycle and ignored otherwise.
- start while busy is ignored; no queuing.
- hold=1:
  - No state, counter, idx, bus_out, a_d, cs_n or rd_data change.
  - done and rd_valid are forced 0; a pending pulse is delayed until the first edge after hold falls, not lost.
  - hold in IDLE blocks start.
- Simultaneous hold and last DATA edge: hold wins; capture happens on the first non-hold last-DATA edge.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Default params: reset 3 cycles, pulse start 1 cycle → bus_out sequence per register is 0x43,0x43,0xF0,0xF0,0xFF,0xFF, then 0x21…. cs_n low for 54 cycles, done pulses once, 9 rd_valid pulses with rd_index 0..8.
- Drive bus_in=0x10+idx during each DATA phase → rd_data equals 0x10..0x18 in order, each coincident with rd_valid; the last one coincides with done.
- Assert hold for 5 cycles during the CMD phase of idx 3 → bus_out stays 0xF0 and cs_n stays 0; total sequence stretches to 59 cycles; captured values are unchanged.
- loop=1 → after idx 8 the FSM returns to ADDR with bus_out=0x43 on the next cycle, done pulses each pass, cs_n never rises, busy stays 1; drop loop → IDLE after the following pass.
- Assert reset during the DATA phase of idx 5 → next cycle all outputs are at reset values, no done; a following start runs a full clean sequence from idx 0.
- PHASE_CYC=1, NUM_REGS=2, ADDR_LIST=16'hAA55 → bus_out is 0x55,0xF0,0xFF,0xAA,0xF0,0xFF; done at cycle 7 after start; start pulsed mid-sequence is ignored.
